ser2par_align: RTL

Parametrised fabric deserializer with comma-based word alignment: it assembles a qualified serial bit stream into WIDTH-bit words, hunts for a comma pattern (default K28.5, both disparities) and locks the word boundary to it with hysteresis. It replaces the fixed 10-bit vendor-primitive deserializer wherever bits already arrive in fabric, for example from an oversampling front end, and feeds the 8b/10b decoder.

---
 rtl/ser2par_pkg.sv | 19 +
 rtl/ser2par_comma_det.sv | 34 +++
 rtl/ser2par_align.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ser2par_pkg.sv
// ser2par_pkg: alignment FSM states and the two K28.5 running-disparity encodings.
// Rev 1.0
`default_nettype none

package ser2par_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // LSB is the first bit on the wire.
   localparam logic [9:0] K28P5_RDN = 10'b0101111100;
   localparam logic [9:0] K28P5_RDP = 10'b1010000011;

endpackage

`default_nettype wire

// File: rtl/ser2par_comma_det.sv
// ser2par_comma_det: masked compare of a window against a comma and, optionally, its inverse.
// Rev 1.0
`default_nettype none

module ser2par_comma_det
   import ser2par_pkg::*;
#(
   parameter int               WIDTH      = 10,
   parameter logic [WIDTH-1:0] COMMA      = K28P5_RDN,
   parameter logic [WIDTH-1:0] COMMA_MASK = '1,
   parameter bit               MATCH_INV  = 1'b1
) (
   input  logic [WIDTH-1:0] window,
   output logic             match
);

   logic hit_pos;
   logic hit_neg;

   assign hit_pos = ((window ^ COMMA) & COMMA_MASK) == '0;

   generate
      if (MATCH_INV) begin : g_inv
         assign hit_neg = ((window ^ ~COMMA) & COMMA_MASK) == '0;
      end else begin : g_no_inv
         assign hit_neg = 1'b0;
      end
   endgenerate

   assign match = hit_pos | hit_neg;

endmodule

`default_nettype wire

// File: rtl/ser2par_align.sv
// ser2par_align: serial-to-parallel deserializer that locks its word boundary to a comma.
// Rev 1.0
`default_nettype none

module ser2par_align
   import ser2par_pkg::*;
#(
   parameter int               WIDTH      = 10,
   parameter logic [WIDTH-1:0] COMMA      = K28P5_RDN,
   parameter logic [WIDTH-1:0] COMMA_MASK = '1,
   parameter bit               MATCH_INV  = 1'b1,
   parameter int               LOCK_CNT   = 3,
   parameter int               UNLOCK_CNT = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ser_valid_i,
   input  logic             ser_data_i,
   input  logic             align_en_i,
   output logic [WIDTH-1:0] par_data_o,
   output logic             par_valid_o,
   output logic             comma_o,
   output logic             locked_o
);

   localparam int PW = $clog2(WIDTH);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_CNT + 1);

   localparam logic [PW-1:0] PH_LAST  = PW'(WIDTH - 1);
   localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);
   localparam logic [BW-1:0] BAD_MAX  = BW'(UNLOCK_CNT);

   logic [WIDTH-1:0] sr;
   logic [PW-1:0]    ph;
   state_t           state;
   state_t           state_nx;
   logic [GW-1:0]    good;
   logic [GW-1:0]    good_nx;
   logic [GW-1:0]    good_inc;
   logic [BW-1:0]    bad;
   logic [BW-1:0]    bad_nx;
   logic [BW-1:0]    bad_inc;
   logic [WIDTH-1:0] window;
   logic             boundary;
   logic             match;
   logic             realign;
   logic             emit;

   assign window   = {ser_data_i, sr[WIDTH-1:1]};
   assign boundary = (ph == PH_LAST);
   assign good_inc = (good == GOOD_MAX) ? good : good + GW'(1);
   assign bad_inc  = (bad == BAD_MAX) ? bad : bad + BW'(1);

   ser2par_comma_det #(
      .WIDTH      (WIDTH),
      .COMMA      (COMMA),
      .COMMA_MASK (COMMA_MASK),
      .MATCH_INV  (MATCH_INV)
   ) u_comma_det (
      .window (window),
      .match  (match)
   );

   always_comb begin
      state_nx = state;
      good_nx  = good;
      bad_nx   = bad;
      realign  = 1'b0;
      if (ser_valid_i && align_en_i && match) begin
         case (state)
            HUNT: begin
               good_nx = GW'(1);
               realign = !boundary;
               if (LOCK_CNT == 1) begin
                  state_nx = LOCKED;
                  bad_nx   = '0;
               end else begin
                  state_nx = CHECK;
               end
            end
            CHECK: begin
               if (boundary) begin
                  good_nx = good_inc;
                  if (good_inc == GOOD_MAX) begin
                     state_nx = LOCKED;
                     bad_nx   = '0;
                  end
               end else begin
                  realign = 1'b1;
                  good_nx = GW'(1);
               end
            end
            LOCKED: begin
               if (boundary) begin
                  bad_nx = '0;
               end else if (bad_inc == BAD_MAX) begin
                  // Too many commas off the boundary: drop lock and move to the new one.
                  state_nx = CHECK;
                  good_nx  = GW'(1);
                  bad_nx   = '0;
                  realign  = 1'b1;
               end else begin
                  bad_nx = bad_inc;
               end
            end
            default: state_nx = HUNT;
         endcase
      end
   end

   assign emit = ser_valid_i && (boundary || realign);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr          <= '0;
         ph          <= '0;
         state       <= HUNT;
         good        <= '0;
         bad         <= '0;
         par_data_o  <= '0;
         par_valid_o <= 1'b0;
         comma_o     <= 1'b0;
      end else begin
         state       <= state_nx;
         good        <= good_nx;
         bad         <= bad_nx;
         par_valid_o <= emit;
         if (ser_valid_i) begin
            sr <= window;
            ph <= (boundary || realign) ? '0 : ph + PW'(1);
         end
         if (emit) begin
            par_data_o <= window;
            comma_o    <= match;
         end
      end
   end

   assign locked_o = (state == LOCKED);

endmodule

`default_nettype wire
